// File: rtl/jt1942_timer.sv
// Video timing generator: H/V pixel and line counters plus registered blanking,
// sync, init strobes and frame toggle, all advancing on the 6 MHz pixel enable.
module jt1942_timer #(
  parameter int unsigned HTOTAL   = 384,
  parameter int unsigned VTOTAL   = 264,
  parameter int unsigned HB_START = 256,
  parameter int unsigned VB_END   = 16,
  parameter int unsigned VB_START = 240,
  parameter int unsigned HS_START = 296,
  parameter int unsigned HS_END   = 328,
  parameter int unsigned VS_START = 248,
  parameter int unsigned VS_END   = 252
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen6,
  output logic [8:0] H,
  output logic [8:0] V,
  output logic       Hinit,
  output logic       Vinit,
  output logic       LHBL,
  output logic       LVBL,
  output logic       HS,
  output logic       VS,
  output logic       frame
);

  localparam int unsigned CW = 9;

  logic [CW-1:0] h_nxt;
  logic [CW-1:0] v_nxt;
  logic          h_wrap;
  logic          v_wrap;
  logic          hinit_nxt;
  logic          vinit_nxt;
  logic          lhbl_nxt;
  logic          lvbl_nxt;
  logic          hs_nxt;
  logic          vs_nxt;

  // Next counter values; wrap is decided from the current count so H/V never
  // reach HTOTAL/VTOTAL.
  always_comb begin
    h_wrap = (H == CW'(HTOTAL - 1));
    v_wrap = (V == CW'(VTOTAL - 1));
    h_nxt  = h_wrap ? '0 : H + CW'(1);
    v_nxt  = V;
    if (h_wrap) begin
      v_nxt = v_wrap ? '0 : V + CW'(1);
    end
  end

  // Decode from the next counts so registered flags line up with H/V.
  always_comb begin
    hinit_nxt = (h_nxt == CW'(HTOTAL - 1));
    vinit_nxt = hinit_nxt && (v_nxt == CW'(VTOTAL - 1));
    lhbl_nxt  = (h_nxt < CW'(HB_START));
    lvbl_nxt  = (v_nxt >= CW'(VB_END)) && (v_nxt < CW'(VB_START));
    hs_nxt    = !((h_nxt >= CW'(HS_START)) && (h_nxt < CW'(HS_END)));
    vs_nxt    = !((v_nxt >= CW'(VS_START)) && (v_nxt < CW'(VS_END)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      H     <= '0;
      V     <= '0;
      Hinit <= 1'b0;
      Vinit <= 1'b0;
      LHBL  <= 1'b1;
      LVBL  <= 1'b0;
      HS    <= 1'b1;
      VS    <= 1'b1;
      frame <= 1'b0;
    end else if (cen6) begin
      H     <= h_nxt;
      V     <= v_nxt;
      Hinit <= hinit_nxt;
      Vinit <= vinit_nxt;
      LHBL  <= lhbl_nxt;
      LVBL  <= lvbl_nxt;
      HS    <= hs_nxt;
      VS    <= vs_nxt;
      if (h_wrap && v_wrap) begin
        frame <= !frame;
      end
    end
  end

endmodule

// File: tb/tb_jt1942_timer.sv
// Bench for jt1942_timer: a default-geometry instance and a small-geometry
// instance run side by side against a modular-arithmetic model of the raster.
module tb_jt1942_timer;

  localparam int S_HT = 20, S_VT = 14, S_HBS = 12, S_VBE = 2, S_VBS = 11;
  localparam int S_HSS = 14, S_HSE = 17, S_VSS = 12, S_VSE = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cen6 = 1'b0;

  logic [8:0] h0, v0, h1, v1;
  logic hinit0, vinit0, lhbl0, lvbl0, hs0, vs0, frame0;
  logic hinit1, vinit1, lhbl1, lvbl1, hs1, vs1, frame1;

  int errors = 0;
  int checks = 0;

  int mh0 = 0, mv0 = 0, mh1 = 0, mv1 = 0;
  bit mf0 = 1'b0, mf1 = 1'b0;

  always #5 clk = ~clk;

  jt1942_timer dut0 (
    .clk(clk), .rst(rst), .cen6(cen6), .H(h0), .V(v0), .Hinit(hinit0),
    .Vinit(vinit0), .LHBL(lhbl0), .LVBL(lvbl0), .HS(hs0), .VS(vs0), .frame(frame0)
  );

  jt1942_timer #(
    .HTOTAL(S_HT), .VTOTAL(S_VT), .HB_START(S_HBS), .VB_END(S_VBE), .VB_START(S_VBS),
    .HS_START(S_HSS), .HS_END(S_HSE), .VS_START(S_VSS), .VS_END(S_VSE)
  ) dut1 (
    .clk(clk), .rst(rst), .cen6(cen6), .H(h1), .V(v1), .Hinit(hinit1),
    .Vinit(vinit1), .LHBL(lhbl1), .LVBL(lvbl1), .HS(hs1), .VS(vs1), .frame(frame1)
  );

  // Raster position model: a pixel index modulo the line length, carrying into
  // a line index modulo the frame height, carrying into the frame parity.
  always @(posedge clk) begin
    if (rst) begin
      mh0 <= 0; mv0 <= 0; mf0 <= 1'b0;
      mh1 <= 0; mv1 <= 0; mf1 <= 1'b0;
    end else if (cen6) begin
      mh0 <= (mh0 + 1) % 384;
      if (mh0 == 383) begin
        mv0 <= (mv0 + 1) % 264;
        if (mv0 == 263) mf0 <= ~mf0;
      end
      mh1 <= (mh1 + 1) % S_HT;
      if (mh1 == S_HT - 1) begin
        mv1 <= (mv1 + 1) % S_VT;
        if (mv1 == S_VT - 1) mf1 <= ~mf1;
      end
    end
  end

  function automatic logic [22:0] expv(input int h, input int v, input bit f,
      input int ht, input int vt, input int hbs, input int vbe, input int vbs,
      input int hss, input int hse, input int vss, input int vse);
    logic hi, vi, lh, lv, hs, vs;
    hi = (h == ht - 1);
    vi = hi && (v == vt - 1);
    lh = (h < hbs);
    lv = (v >= vbe) && (v < vbs);
    hs = !(h >= hss && h < hse);
    vs = !(v >= vss && v < vse);
    return {9'(h), 9'(v), hi, vi, lh, lv, hs, vs, f};
  endfunction

  wire [22:0] d0 = {h0, v0, hinit0, vinit0, lhbl0, lvbl0, hs0, vs0, frame0};
  wire [22:0] d1 = {h1, v1, hinit1, vinit1, lhbl1, lvbl1, hs1, vs1, frame1};
  wire [22:0] e0 = expv(mh0, mv0, mf0, 384, 264, 256, 16, 240, 296, 328, 248, 252);
  wire [22:0] e1 = expv(mh1, mv1, mf1, S_HT, S_VT, S_HBS, S_VBE, S_VBS,
                        S_HSS, S_HSE, S_VSS, S_VSE);
  localparam logic [22:0] RST_VEC = {9'd0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  task automatic cyc(input logic c, input logic r);
    cen6 = c;
    rst  = r;
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'b1);
      checks++;
      if (d0 !== RST_VEC) begin errors++; $display("FAIL reset0: got %h expected %h", d0, RST_VEC); end
      checks++;
      if (d1 !== RST_VEC) begin errors++; $display("FAIL reset1: got %h expected %h", d1, RST_VEC); end
    end
  endtask

  task automatic test_first_cen();
    cyc(1'b1, 1'b0);
    checks++;
    if (h0 !== 9'd1 || v0 !== 9'd0 || lvbl0 !== 1'b0 || lhbl0 !== 1'b1) begin
      errors++;
      $display("FAIL first_cen: got H=%0d V=%0d LVBL=%b LHBL=%b expected H=1 V=0 LVBL=0 LHBL=1",
               h0, v0, lvbl0, lhbl0);
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
    checks++;
    if (d0 !== e0) begin errors++; $display("FAIL first_cen_hold: got %h expected %h", d0, e0); end
  endtask

  task automatic test_line_wrap();
    int n = 0;
    int vprev;
    int act = 0, hsl = 0;
    while (h0 !== 9'd383 && n < 2000) begin
      cyc(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
      checks++;
      if (d0 !== e0) begin errors++; $display("FAIL line_run: got %h expected %h", d0, e0); end
      n++;
    end
    checks++;
    if (h0 !== 9'd383 || hinit0 !== 1'b1 || lhbl0 !== 1'b0) begin
      errors++;
      $display("FAIL line_end: got H=%0d Hinit=%b LHBL=%b expected H=383 Hinit=1 LHBL=0",
               h0, hinit0, lhbl0);
    end
    vprev = mv0;
    cyc(1'b1, 1'b0);
    checks++;
    if (h0 !== 9'd0 || v0 !== 9'(vprev + 1) || hinit0 !== 1'b0 || lhbl0 !== 1'b1) begin
      errors++;
      $display("FAIL line_wrap: got H=%0d V=%0d Hinit=%b LHBL=%b expected H=0 V=%0d Hinit=0 LHBL=1",
               h0, v0, hinit0, lhbl0, vprev + 1);
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
    for (int p = 0; p < 384; p++) begin
      if (lhbl0) act++;
      if (!hs0) hsl++;
      cyc(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
    end
    checks++;
    if (act != 256 || hsl != 32) begin
      errors++;
      $display("FAIL line_counts: got active=%0d hs_low=%0d expected active=256 hs_low=32", act, hsl);
    end
    checks++;
    if (h0 !== 9'd0) begin errors++; $display("FAIL line_period: got H=%0d expected H=0", h0); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 499) == 0));
      checks++;
      if (d0 !== e0) begin errors++; $display("FAIL random0 cyc%0d: got %h expected %h", i, d0, e0); end
      checks++;
      if (d1 !== e1) begin errors++; $display("FAIL random1 cyc%0d: got %h expected %h", i, d1, e1); end
    end
  endtask

  task automatic test_frame_wrap();
    int n = 0;
    bit fprev;
    int lv = 0, vsl = 0, hsl = 0;
    cyc(1'b0, 1'b0);
    while (!(h1 === 9'(S_HT - 1) && v1 === 9'(S_VT - 1)) && n < 1000) begin
      cyc(1'b1, 1'b0);
      n++;
    end
    checks++;
    if (vinit1 !== 1'b1 || hinit1 !== 1'b1 || n >= 1000) begin
      errors++;
      $display("FAIL frame_end: got Vinit=%b Hinit=%b steps=%0d expected Vinit=1 Hinit=1", vinit1, hinit1, n);
    end
    fprev = mf1;
    cyc(1'b1, 1'b0);
    checks++;
    if (h1 !== 9'd0 || v1 !== 9'd0 || frame1 !== ~fprev || vinit1 !== 1'b0) begin
      errors++;
      $display("FAIL frame_wrap: got H=%0d V=%0d frame=%b Vinit=%b expected H=0 V=0 frame=%b Vinit=0",
               h1, v1, frame1, vinit1, ~fprev);
    end
    n = 0;
    do begin
      if (h1 == 9'd0 && lvbl1) lv++;
      if (h1 == 9'd0 && !vs1) vsl++;
      if (v1 == 9'd0 && !hs1) hsl++;
      cyc(1'b1, 1'b0);
      n++;
      checks++;
      if (d1 !== e1) begin errors++; $display("FAIL frame_run: got %h expected %h", d1, e1); end
    end while (!(h1 === 9'd0 && v1 === 9'd0) && n < 1000);
    checks++;
    if (n != S_HT * S_VT || lv != S_VBS - S_VBE || vsl != S_VSE - S_VSS || hsl != S_HSE - S_HSS) begin
      errors++;
      $display("FAIL frame_counts: got cen=%0d lvbl_lines=%0d vs_lines=%0d hs_px=%0d expected %0d %0d %0d %0d",
               n, lv, vsl, hsl, S_HT * S_VT, S_VBS - S_VBE, S_VSE - S_VSS, S_HSE - S_HSS);
    end
  endtask

  task automatic test_hold();
    int n = 0;
    int hh;
    while (!(h0 >= 9'd100 && h0 <= 9'd200) && n < 400) begin
      cyc(1'b1, 1'b0);
      n++;
    end
    hh = mh0;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b0, 1'b0);
      checks++;
      if (d0 !== e0 || h0 !== 9'(hh)) begin
        errors++;
        $display("FAIL hold0 cyc%0d: got %h expected %h", i, d0, e0);
      end
      checks++;
      if (d1 !== e1) begin errors++; $display("FAIL hold1 cyc%0d: got %h expected %h", i, d1, e1); end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    cyc(1'b0, 1'b1);
    while (!(h0 === 9'd150 && v0 === 9'd100) && n < 40000) begin
      cyc(1'b1, 1'b0);
      n++;
      checks++;
      if (d0 !== e0) begin errors++; $display("FAIL mid_run step%0d: got %h expected %h", n, d0, e0); end
    end
    checks++;
    if (n != 100 * 384 + 150) begin
      errors++;
      $display("FAIL mid_reach: got steps=%0d expected %0d", n, 100 * 384 + 150);
    end
    cyc(1'b0, 1'b1);
    checks++;
    if (h0 !== 9'd0 || v0 !== 9'd0 || lvbl0 !== 1'b0 || d0 !== RST_VEC) begin
      errors++;
      $display("FAIL mid_reset: got %h expected %h", d0, RST_VEC);
    end
    cyc(1'b1, 1'b1);
    checks++;
    if (d0 !== RST_VEC) begin errors++; $display("FAIL mid_reset_cen: got %h expected %h", d0, RST_VEC); end
    cyc(1'b0, 1'b0);
    checks++;
    if (d0 !== RST_VEC) begin errors++; $display("FAIL mid_idle: got %h expected %h", d0, RST_VEC); end
    cyc(1'b1, 1'b0);
    checks++;
    if (h0 !== 9'd1 || v0 !== 9'd0 || d0 !== e0) begin
      errors++;
      $display("FAIL mid_resume: got %h expected %h", d0, e0);
    end
  endtask

  initial begin
    test_reset();
    test_first_cen();
    test_line_wrap();
    test_random();
    test_frame_wrap();
    test_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jt1942_timer.md
JT1942_TIMER -- requirements
Module: jt1942_timer

Interface
REQ-001 Parameter HTOTAL, default 384: pixels per line; H counts 0..HTOTAL-1.
REQ-002 Parameter VTOTAL, default 264: lines per frame; V counts 0..VTOTAL-1.
REQ-003 Parameter HB_START, default 256: first blanked H value; H 0..HB_START-1 is active.
REQ-004 Parameter VB_END, default 16: first active line.
REQ-005 Parameter VB_START, default 240: first blanked line after the active region.
REQ-006 Parameters HS_START/HS_END, default 296/328: HS is low for H in [HS_START, HS_END).
REQ-007 Parameters VS_START/VS_END, default 248/252: VS is low for V in [VS_START, VS_END).
REQ-008 Port clk, input, 1: 24 MHz system clock; the only clock in the block.
REQ-009 Port rst, input, 1: synchronous, active-high reset.
REQ-010 Port cen6, input, 1: 6 MHz pixel clock enable, one clk wide.
REQ-011 Port H, output, 9: horizontal pixel count; H[7:0] feeds the tile layers as H128.
REQ-012 Port V, output, 9: line count; V[7:0] feeds the tile layers as V128.
REQ-013 Port Hinit, output, 1: high while H==HTOTAL-1.
REQ-014 Port Vinit, output, 1: high while V==VTOTAL-1 and H==HTOTAL-1.
REQ-015 Port LHBL, output, 1: active-low horizontal blank (high during active pixels).
REQ-016 Port LVBL, output, 1: active-low vertical blank.
REQ-017 Port HS, output, 1: active-low horizontal sync.
REQ-018 Port VS, output, 1: active-low vertical sync.
REQ-019 Port frame, output, 1: toggles once per frame.

Function
REQ-020 All state (H, V, LHBL, LVBL, HS, VS, Hinit, Vinit, frame) shall be registered on posedge clk and shall update only on cycles with cen6=1; with cen6=0 all outputs hold.
REQ-021 On each cen6 cycle, H shall increment by 1; at H==HTOTAL-1, H shall wrap to 0.
REQ-022 V shall increment only on the cen6 cycle where H wraps; at V==VTOTAL-1, V shall wrap to 0 on the same cycle as H.
REQ-023 The frame output shall toggle on the cen6 cycle where both H and V wrap.
REQ-024 Decoded outputs shall be computed from the next counter values and registered on the same edge, so they match the H/V visible in the same clk cycle; no extra pipeline latency.
REQ-025 LHBL shall be 1 iff H<HB_START; LVBL shall be 1 iff VB_END<=V<VB_START.
REQ-026 HS and VS shall be 0 exactly within their parameter ranges and 1 elsewhere.
REQ-027 With default parameters, each line shall have 256 active and 128 blanked pixels, and each frame 224 active and 40 blanked lines.
REQ-028 Hinit shall be high for one full H count (4 clk at 24 MHz/cen6 every 4th clk); Vinit shall be high once per frame for the same duration.
REQ-029 Counter arithmetic is 9-bit unsigned; H and V shall never reach HTOTAL or VTOTAL respectively, even transiently.

Reset
REQ-030 While rst=1 at a clk edge, regardless of cen6: H=0, V=0, LHBL=1, LVBL=0, HS=1, VS=1, Hinit=0, Vinit=0, frame=0.
REQ-031 Reset asserted mid-frame shall take effect at the next clk edge; counting resumes from H=0, V=0 on the first cen6 after rst deasserts.

Verification
REQ-032 Reset, then apply cen6 every 4th clk: on the first cen6, H goes 0->1, V stays 0, LVBL=0, LHBL=1.
REQ-033 Run to H=383 (Hinit=1, LHBL=0); on the next cen6, H=0, V=V+1, Hinit=0, LHBL=1.
REQ-034 Run from V=263, H=383 (Vinit=1): on the next cen6, H=0, V=0, frame toggles, Vinit=0.
REQ-035 Run one full frame and count the cycles: 101376 cen6 pulses per frame, 224 lines with LVBL=1, 32 pixels per line with HS=0, 4 lines with VS=0.
REQ-036 Hold cen6=0 for 100 clk mid-line: all outputs remain constant; then assert rst with cen6=0 at H=150, V=100: the next edge gives H=0, V=0, LVBL=0.
